// File: rtl/bombsquad_pkg.sv
// Shared definitions for the bombsquad game datapath: default widths, user
// count and the level store's sweep/ready state encoding.
package bombsquad_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int NUM_USERS = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/level_ram_array.sv
// DEPTH x DATA_W level storage: one write port and two registered read ports
// (controller and display). Contents are not reset; the read registers are.
module level_ram_array #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_load,
  input  logic              rd_zero,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              disp_ok,
  input  logic [IDX_W-1:0]  disp_idx,
  output logic [DATA_W-1:0] disp_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Both read ports see the pre-write contents on a colliding edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data   <= '0;
      disp_data <= '0;
    end else begin
      if (rd_load) begin
        rd_data <= rd_zero ? '0 : mem[raddr];
      end
      disp_data <= disp_ok ? mem[disp_idx] : '0;
    end
  end

endmodule

// File: rtl/level_ram.sv
// Per-user level store behind the RAM controller: post-reset clear sweep,
// range-checked controller reads/writes, display read port, write counter.
module level_ram
  import bombsquad_pkg::*;
#(
  parameter int DEPTH  = bombsquad_pkg::NUM_USERS,
  parameter int ADDR_W = bombsquad_pkg::ADDR_W,
  parameter int DATA_W = bombsquad_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              r_w,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  input  logic [1:0]        disp_addr,
  output logic [DATA_W-1:0] disp_level,
  output logic [15:0]       wr_count,
  output state_e            state
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW_MAX = (ADDR_W > IDX_W) ? ADDR_W : IDX_W;
  localparam int CW     = AW_MAX + 1;
  localparam int DW_MAX = (IDX_W > 2) ? IDX_W : 2;
  localparam int DCW    = DW_MAX + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  // Controller protocol: there is no handshake beyond busy. While busy is
  // high every cycle of r_w/address/data_in is discarded; once low, each
  // cycle is one transaction (r_w=1 write, r_w=0 read with data_out valid
  // after the next edge). Out-of-range writes are dropped, reads return 0.

  state_e            state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              addr_ok, disp_ok;
  logic              mem_we, rd_load, rd_zero, cnt_inc;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign addr_ok = CW'(address) < CW'(DEPTH);
  assign disp_ok = DCW'(disp_addr) < DCW'(DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      idx_q <= '0;
    end else begin
      state <= state_d;
      idx_q <= idx_d;
    end
  end

  always_comb begin
    state_d   = state;
    idx_d     = idx_q;
    mem_we    = 1'b0;
    mem_waddr = idx_q;
    mem_wdata = '0;
    rd_load   = 1'b0;
    rd_zero   = 1'b0;
    cnt_inc   = 1'b0;
    busy      = 1'b0;
    case (state)
      CLEAR: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        if (idx_q == LAST) begin
          state_d = READY;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      READY: begin
        if (r_w) begin
          if (addr_ok) begin
            mem_we    = 1'b1;
            mem_waddr = IDX_W'(address);
            mem_wdata = data_in;
            cnt_inc   = 1'b1;
          end
        end else begin
          rd_load = 1'b1;
          rd_zero = !addr_ok;
        end
      end
      default: begin
        state_d = CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count <= '0;
    end else if (cnt_inc && (wr_count != 16'hFFFF)) begin
      wr_count <= wr_count + 16'd1;
    end
  end

  level_ram_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .we        (mem_we),
    .waddr     (mem_waddr),
    .wdata     (mem_wdata),
    .rd_load   (rd_load),
    .rd_zero   (rd_zero),
    .raddr     (IDX_W'(address)),
    .rd_data   (data_out),
    .disp_ok   (disp_ok),
    .disp_idx  (IDX_W'(disp_addr)),
    .disp_data (disp_level)
  );

endmodule
